// File: rtl/alu_pipe.sv
// Two-stage pipelined WIDTH-bit ALU with valid/ready handshakes on both sides,
// registered carry/zero/overflow flags and an accumulator that can stand in
// for operand A.
module alu_pipe #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    input  logic             use_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned XW = WIDTH + 1;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] acc_q, acc_d;

    logic             s2_adv;
    logic             hazard;
    logic             accept;
    logic             out_hs;

    logic [WIDTH-1:0] lhs, rhs, alu_res;
    logic [XW-1:0]    sum_x, diff_x;
    logic             is_add, is_sub, alu_c, alu_v;

    // Handshake control; an acc-based op waits until the pipe is fully retired
    always_comb begin
        s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
        hazard   = in_valid && use_acc && (s1_valid_q || s2_valid_q);
        in_ready = (!s1_valid_q || s2_adv) && !hazard;
        accept   = in_valid && in_ready;
        out_hs   = s2_valid_q && out_ready;
    end

    // Stage 1: capture operands (accumulator read here, before any same-edge clear)
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = use_acc ? acc_q : a;
            s1_b_d     = b;
            s1_op_d    = opcode;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Operation decode onto a single adder/subtractor; inc/dec use constant 1
    always_comb begin
        lhs    = s1_a_q;
        rhs    = s1_b_q;
        is_add = 1'b0;
        is_sub = 1'b0;
        case (s1_op_q)
            3'b000: is_add = 1'b1;
            3'b001: is_sub = 1'b1;
            3'b010: lhs = s1_a_q;
            3'b011: lhs = s1_b_q;
            3'b100: begin rhs = WIDTH'(1); is_sub = 1'b1; end
            3'b101: begin lhs = s1_b_q; rhs = WIDTH'(1); is_sub = 1'b1; end
            3'b110: begin rhs = WIDTH'(1); is_add = 1'b1; end
            3'b111: begin lhs = s1_b_q; rhs = WIDTH'(1); is_add = 1'b1; end
            default: lhs = '0;
        endcase

        sum_x   = {1'b0, lhs} + {1'b0, rhs};
        diff_x  = {1'b0, lhs} - {1'b0, rhs};
        alu_res = lhs;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        if (is_add) begin
            alu_res = sum_x[WIDTH-1:0];
            alu_c   = sum_x[WIDTH];
            alu_v   = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (alu_res[WIDTH-1] != lhs[WIDTH-1]);
        end else if (is_sub) begin
            alu_res = diff_x[WIDTH-1:0];
            alu_c   = diff_x[WIDTH];
            alu_v   = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (alu_res[WIDTH-1] != lhs[WIDTH-1]);
        end
    end

    // Stage 2: register result and flags; hold them while downstream stalls
    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        if (s2_adv) begin
            s2_valid_d = 1'b1;
            result_d   = alu_res;
            carry_d    = alu_c;
            zero_d     = (alu_res == '0);
            overflow_d = alu_v;
        end else if (out_hs) begin
            s2_valid_d = 1'b0;
        end
    end

    // Accumulator: a clear wins over a retiring result on the same edge
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = ACC_RST;
        end else if (out_hs) begin
            acc_d = result_q;
        end
    end

    // Pipeline and accumulator registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            acc_q      <= ACC_RST;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            acc_q      <= acc_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed table, accumulator/backpressure/reset sequences,
// randomized ops against an integer-arithmetic reference, and an 8-bit instance.
module tb_alu_pipe;

    localparam int unsigned      W    = 32;
    localparam logic [W-1:0]     ACC0 = '0;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic [2:0]   opcode;
    logic         use_acc, acc_clr;
    logic         out_valid, out_ready;
    logic [W-1:0] result;
    logic         carry, zero, overflow;

    logic         in_valid8, in_ready8;
    logic [7:0]   a8, b8, result8;
    logic [2:0]   opcode8;
    logic         out_valid8, out_ready8;
    logic         carry8, zero8, overflow8;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .ACC_RST(ACC0)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .use_acc(use_acc), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .overflow(overflow)
    );

    alu_pipe #(.WIDTH(8), .ACC_RST(8'h00)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .opcode(opcode8), .use_acc(1'b0), .acc_clr(1'b0),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .carry(carry8), .zero(zero8), .overflow(overflow8)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ua;
        logic         use_model;
        logic         chk_lat;
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
    } op_t;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
        int           acc_cyc;
        logic         chk_lat;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
    } v8_t;

    op_t          drv_q[$];
    exp_t         exp_q[$];
    int           n_checks, n_errors;
    int           cyc, accept_cnt, pop_cnt, stall_cnt;
    logic         or_level, bp_random, prev_hold;
    logic [W-1:0] m_acc, hold_res;
    logic [2:0]   hold_flags;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: exact integer arithmetic, flags from value ranges
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint m, x, y, sx, sy, exact, r;
        int     kind;
        exp_t   e;
        m = longint'(1) << W;
        x = 0; y = 0; kind = 2;
        case (op)
            3'd0: begin x = longint'(av); y = longint'(bv); kind = 0; end
            3'd1: begin x = longint'(av); y = longint'(bv); kind = 1; end
            3'd2: begin x = longint'(av); end
            3'd3: begin x = longint'(bv); end
            3'd4: begin x = longint'(av); y = longint'(1); kind = 1; end
            3'd5: begin x = longint'(bv); y = longint'(1); kind = 1; end
            3'd6: begin x = longint'(av); y = longint'(1); kind = 0; end
            default: begin x = longint'(bv); y = longint'(1); kind = 0; end
        endcase
        sx = (x >= m / 2) ? x - m : x;
        sy = (y >= m / 2) ? y - m : y;
        if (kind == 0) begin
            r = (x + y) % m;  e.c = ((x + y) >= m);  exact = sx + sy;
        end else if (kind == 1) begin
            r = (x - y + m) % m;  e.c = (x < y);  exact = sx - sy;
        end else begin
            r = x;  e.c = 1'b0;  exact = sx;
        end
        e.v       = (exact > m / 2 - 1) || (exact < -(m / 2));
        e.res     = W'(r);
        e.z       = (r == 0);
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    function automatic op_t mk(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic ua, input logic lat, input logic [W-1:0] res,
                               input logic c, input logic z, input logic v);
        op_t o;
        o.op = op; o.a = av; o.b = bv; o.ua = ua; o.use_model = 1'b0; o.chk_lat = lat;
        o.res = res; o.c = c; o.z = z; o.v = v;
        return o;
    endfunction

    function automatic op_t mkr(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv, input logic ua);
        op_t o;
        o = mk(op, av, bv, ua, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        o.use_model = 1'b1;
        return o;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Drive the head of the op queue and out_ready for the coming cycle
    task automatic present();
        out_ready = bp_random ? 1'($urandom_range(0, 1)) : or_level;
        if (drv_q.size() > 0 && !rst) begin
            in_valid = 1'b1;
            a        = drv_q[0].a;
            b        = drv_q[0].b;
            opcode   = drv_q[0].op;
            use_acc  = drv_q[0].ua;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // One clock: sample at negedge (hold, retire, accept), then re-drive after posedge
    task automatic step();
        op_t  o;
        exp_t e;
        @(negedge clk);
        cyc++;
        if (prev_hold) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_result", 64'(result), 64'(hold_res));
            chk("hold_flags", 64'({carry, zero, overflow}), 64'(hold_flags));
        end
        prev_hold  = out_valid && !out_ready && !rst;
        hold_res   = result;
        hold_flags = {carry, zero, overflow};
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_result: got 0x%0h with no op outstanding (cycle %0d)", result, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("carry", 64'(carry), 64'(e.c));
                chk("zero", 64'(zero), 64'(e.z));
                chk("overflow", 64'(overflow), 64'(e.v));
                if (e.chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'(2));
                m_acc = e.res;
                pop_cnt++;
            end
        end
        if (!rst && in_valid && drv_q.size() > 0) begin
            if (in_ready) begin
                o = drv_q.pop_front();
                if (o.use_model) begin
                    e = model(o.op, o.ua ? m_acc : o.a, o.b);
                end else begin
                    e.res = o.res; e.c = o.c; e.z = o.z; e.v = o.v;
                end
                e.acc_cyc = cyc;
                e.chk_lat = o.chk_lat;
                exp_q.push_back(e);
                accept_cnt++;
            end else begin
                stall_cnt++;
            end
        end
        @(posedge clk);
        #1;
        present();
    endtask

    task automatic drain(input int budget, input string name);
        int k;
        k = 0;
        while ((drv_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
            step();
            k++;
        end
        if (drv_q.size() > 0 || exp_q.size() > 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s_drain: %0d unsent and %0d unretired ops after %0d cycles",
                     name, drv_q.size(), exp_q.size(), budget);
        end
        chk({name, "_idle"}, 64'(out_valid), 64'(0));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drv_q.delete();
        exp_q.delete();
        present();
        repeat (n) step();
        rst       = 1'b0;
        m_acc     = ACC0;
        prev_hold = 1'b0;
        present();
    endtask

    op_t vec[$];
    v8_t v8[4];
    int  k0, p0;

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        accept_cnt = 0; pop_cnt = 0; stall_cnt = 0;
        or_level = 1'b1; bp_random = 1'b0; prev_hold = 1'b0;
        m_acc = ACC0; hold_res = '0; hold_flags = '0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; opcode = '0; use_acc = 1'b0; acc_clr = 1'b0;
        out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; opcode8 = '0; out_ready8 = 1'b1;

        // Reset state
        do_reset(3);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_flags", 64'({carry, zero, overflow}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed vectors, back-to-back with no backpressure: {op, a, b} -> {res, c, z, v}
        vec.push_back(mk(3'b000, 32'd5,          32'd7,          0, 1, 32'd12,         0, 0, 0));
        vec.push_back(mk(3'b001, 32'd3,          32'd5,          0, 1, 32'hFFFF_FFFE,  1, 0, 0));
        vec.push_back(mk(3'b000, 32'h7FFF_FFFF,  32'd1,          0, 1, 32'h8000_0000,  0, 0, 1));
        vec.push_back(mk(3'b000, 32'hFFFF_FFFF,  32'd1,          0, 1, 32'h0,          1, 1, 0));
        vec.push_back(mk(3'b100, 32'h0,          32'h1234,       0, 1, 32'hFFFF_FFFF,  1, 0, 0));
        vec.push_back(mk(3'b111, 32'h55,         32'hFFFF_FFFF,  0, 1, 32'h0,          1, 1, 0));
        vec.push_back(mk(3'b011, 32'h55,         32'h0,          0, 1, 32'h0,          0, 1, 0));
        vec.push_back(mk(3'b001, 32'h8000_0000,  32'd1,          0, 1, 32'h7FFF_FFFF,  0, 0, 1));
        vec.push_back(mk(3'b010, 32'h8000_0000,  32'h77,         0, 1, 32'h8000_0000,  0, 0, 0));
        vec.push_back(mk(3'b110, 32'h7FFF_FFFF,  32'h0,          0, 1, 32'h8000_0000,  0, 0, 1));
        vec.push_back(mk(3'b101, 32'h9,          32'h8000_0000,  0, 1, 32'h7FFF_FFFF,  0, 0, 1));
        vec.push_back(mk(3'b001, 32'd5,          32'd5,          0, 1, 32'h0,          0, 1, 0));
        for (int i = 0; i < vec.size(); i++) drv_q.push_back(vec[i]);
        present();
        drain(60, "table");

        // Accumulator chain from reset: three back-to-back INC A from acc
        do_reset(1);
        stall_cnt = 0;
        for (int i = 1; i <= 3; i++) drv_q.push_back(mk(3'b110, 32'h1234, 32'h0, 1, 0, W'(i), 0, 0, 0));
        present();
        drain(60, "acc_chain");
        chk("acc_stalls", 64'(stall_cnt), 64'(4));

        // acc_clr pulse then INC from acc
        acc_clr = 1'b1; present(); step();
        acc_clr = 1'b0; m_acc = ACC0;
        drv_q.push_back(mk(3'b110, 32'hABCD, 32'h0, 1, 0, 32'd1, 0, 0, 0));
        present();
        drain(20, "acc_clr");

        // acc_clr on the same edge as a retiring result: the clear wins
        or_level = 1'b0;
        drv_q.push_back(mk(3'b000, 32'd10, 32'd20, 0, 0, 32'd30, 0, 0, 0));
        present();
        k0 = 0;
        while (!out_valid && k0 < 10) begin step(); k0++; end
        chk("clr_prio_valid", 64'(out_valid), 64'(1));
        or_level = 1'b1; acc_clr = 1'b1; present(); step();
        acc_clr = 1'b0; m_acc = ACC0;
        chk("clr_prio_retired", 64'(exp_q.size()), 64'(0));
        drv_q.push_back(mk(3'b110, 32'h0, 32'h0, 1, 0, 32'd1, 0, 0, 0));
        present();
        drain(20, "clr_prio");

        // acc op accepted with acc_clr reads the pre-clear value (acc=1 -> 2)
        drv_q.push_back(mk(3'b110, 32'h0, 32'h0, 1, 0, 32'd2, 0, 0, 0));
        acc_clr = 1'b1; present(); step();
        acc_clr = 1'b0; present();
        drain(20, "clr_same_cycle");
        drv_q.push_back(mk(3'b110, 32'h0, 32'h0, 1, 0, 32'd3, 0, 0, 0));
        present();
        drain(20, "after_clr_same_cycle");

        // Backpressure: 4 ADDs with out_ready low, then release
        or_level = 1'b0;
        for (int i = 0; i < 4; i++) drv_q.push_back(mkr(3'b000, pick(), pick(), 1'b0));
        present();
        k0 = accept_cnt;
        repeat (6) step();
        chk("bp_accepts", 64'(accept_cnt - k0), 64'(2));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        or_level = 1'b1; present();
        p0 = pop_cnt;
        repeat (4) step();
        chk("bp_release_pops", 64'(pop_cnt - p0), 64'(4));
        chk("bp_release_left", 64'(exp_q.size() + drv_q.size()), 64'(0));
        drain(10, "bp");

        // Reset with two ops in flight
        or_level = 1'b0;
        drv_q.push_back(mkr(3'b001, pick(), pick(), 1'b0));
        drv_q.push_back(mkr(3'b000, pick(), pick(), 1'b0));
        present();
        k0 = accept_cnt;
        p0 = 0;
        while (accept_cnt - k0 < 2 && p0 < 10) begin step(); p0++; end
        chk("mid_rst_accepts", 64'(accept_cnt - k0), 64'(2));
        do_reset(1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_result", 64'(result), 64'(0));
        chk("mid_rst_flags", 64'({carry, zero, overflow}), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        or_level = 1'b1;
        drv_q.push_back(mk(3'b110, 32'h5555, 32'h0, 1, 0, 32'd1, 0, 0, 0));
        present();
        drain(20, "mid_rst");

        // Randomized ops with random backpressure against the reference
        bp_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drv_q.push_back(mkr(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 6) == 0)));
        end
        present();
        drain(6000, "random");
        bp_random = 1'b0; or_level = 1'b1; present();

        // 8-bit instance, back-to-back with out_ready high
        v8[0] = '{op: 3'b000, a: 8'h05, b: 8'h07, res: 8'h0C, c: 1'b0, z: 1'b0, v: 1'b0};
        v8[1] = '{op: 3'b001, a: 8'h03, b: 8'h05, res: 8'hFE, c: 1'b1, z: 1'b0, v: 1'b0};
        v8[2] = '{op: 3'b000, a: 8'h7F, b: 8'h01, res: 8'h80, c: 1'b0, z: 1'b0, v: 1'b1};
        v8[3] = '{op: 3'b000, a: 8'hFF, b: 8'h01, res: 8'h00, c: 1'b1, z: 1'b1, v: 1'b0};
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                in_valid8 = 1'b1; a8 = v8[i].a; b8 = v8[i].b; opcode8 = v8[i].op;
                chk("w8_in_ready", 64'(in_ready8), 64'(1));
            end else begin
                in_valid8 = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i >= 1) begin
                chk("w8_out_valid", 64'(out_valid8), 64'(1));
                chk("w8_result", 64'(result8), 64'(v8[i-1].res));
                chk("w8_flags", 64'({carry8, zero8, overflow8}), 64'({v8[i-1].c, v8[i-1].z, v8[i-1].v}));
            end
        end
        @(posedge clk);
        #1;
        chk("w8_idle", 64'(out_valid8), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
